// File: rtl/gated_det_counter.sv
// Gated event counter: counts synchronized detector edges inside det gates,
// accumulates over frame_len gates and hands each frame result to a consumer.
module gated_det_counter #(
  parameter int CNT_W   = 32,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               det,
  input  logic               det_in,
  input  logic [FRAME_W-1:0] frame_len,
  output logic [CNT_W-1:0]   count_out,
  output logic               count_valid,
  input  logic               count_ready,
  output logic               overrun,
  output logic               saturated,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GATE = 2'd1,
    IN_GATE   = 2'd2,
    FRAME_END = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic               meta_q, sync_q, sync_prev_q, det_q;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [FRAME_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [FRAME_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               sat_q, sat_d;

  logic               event_edge, gate_rise, gate_fall;
  logic [FRAME_W-1:0] gate_inc, len_clamped;

  assign event_edge  = sync_q & ~sync_prev_q;
  assign gate_rise   = det & ~det_q;
  assign gate_fall   = ~det & det_q;
  assign gate_inc    = gate_cnt_q + FRAME_W'(1);
  assign len_clamped = (frame_len == '0) ? FRAME_W'(1) : frame_len;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    acc_d      = acc_q;
    gate_cnt_d = gate_cnt_q;
    len_d      = len_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    sat_d      = sat_q;

    if (valid_q && count_ready) valid_d = 1'b0;

    // Only IN_GATE counts, so a gate already high on entering WAIT_GATE adds nothing.
    if (state_q == IN_GATE && det_q && event_edge && acc_q != CNT_MAX)
      acc_d = acc_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = WAIT_GATE;
          acc_d      = '0;
          gate_cnt_d = '0;
          len_d      = len_clamped;
        end
      end
      WAIT_GATE: begin
        if (gate_rise) state_d = IN_GATE;
      end
      IN_GATE: begin
        if (gate_fall) begin
          gate_cnt_d = gate_inc;
          state_d    = (gate_inc == len_q) ? FRAME_END : WAIT_GATE;
        end
      end
      FRAME_END: begin
        // A handshake this same cycle frees the output register for the new result.
        if (!valid_q || count_ready) begin
          count_d = acc_q;
          sat_d   = (acc_q == CNT_MAX);
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (enable) begin
          state_d    = WAIT_GATE;
          acc_d      = '0;
          gate_cnt_d = '0;
          len_d      = len_clamped;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      det_q       <= 1'b0;
      acc_q       <= '0;
      gate_cnt_q  <= '0;
      len_q       <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      meta_q      <= det_in;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      det_q       <= det;
      acc_q       <= acc_d;
      gate_cnt_q  <= gate_cnt_d;
      len_q       <= len_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      sat_q       <= sat_d;
    end
  end

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign overrun     = overrun_q;
  assign saturated   = sat_q;
  assign busy        = (state_q != IDLE);

endmodule
